// File: rtl/wb_find_master_pkg.sv
// ----------------------------------------------------------------------------
// wb_find_master_pkg
//   Shared definitions for the wb_find Wishbone initiator:
//     - state_e         : initiator FSM state encoding
//     - calc_sel_width  : byte-lane count for a given data width
//     - calc_addr_inc   : byte-address step between consecutive words
//     - tmo_cnt_width   : width of the ack-timeout counter
// ----------------------------------------------------------------------------
package wb_find_master_pkg;

    localparam int unsigned BYTE_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDAT,
        ST_BUS,
        ST_RESP,
        ST_DRAIN
    } state_e;

    function automatic int unsigned calc_sel_width(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    function automatic int unsigned calc_addr_inc(input int unsigned data_width);
        return data_width / BYTE_BITS;
    endfunction

    // Counter only needs to reach TIMEOUT_CYCLES-1; at least one bit.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_find_master_wb_ack_timer.sv
// ----------------------------------------------------------------------------
// wb_ack_timer
//   Per-beat acknowledge watchdog. Cleared by load_i, advances on every
//   cycle count_i is high, and flags expired_o on the TIMEOUT_CYCLES-th
//   counted cycle so the owner can drop the bus on the following edge.
//
//   Ports:
//     clk_i      clock
//     rst_i      synchronous active-high reset
//     load_i     clear the count (start of a new strobe)
//     count_i    one more cycle waited without ack
//     expired_o  combinational: this counted cycle is the last allowed
// ----------------------------------------------------------------------------
module wb_ack_timer
    import wb_find_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int unsigned    CW   = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (count_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign expired_o = count_i && (cnt_q == LAST);

endmodule

// File: rtl/wb_find_master.sv
// ----------------------------------------------------------------------------
// wb_find_master
//   Wishbone classic-cycle initiator issuing single and incrementing-burst
//   reads/writes. Commands, write data and responses use valid/ready
//   streams; every beat is guarded by an ack timeout so a dead slave
//   cannot hang the bus.
//
//   Ports:
//     wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//     cmd_*                    command stream (we, start adr, sel, len=words-1)
//     wdat_*                   write-data stream, one word per write beat
//     rsp_*                    response stream: read data per beat, or one
//                              status beat for writes / timeouts
//     busy                     a command is in progress
//     wbm_*                    Wishbone master signals
// ----------------------------------------------------------------------------
module wb_find_master
    import wb_find_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    input  logic [LEN_WIDTH-1:0]    cmd_len,

    input  logic                    wdat_valid,
    output logic                    wdat_ready,
    input  logic [DATA_WIDTH-1:0]   wdat,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_dat,
    output logic                    rsp_last,
    output logic                    rsp_err,

    output logic                    busy,

    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i
);

    localparam int unsigned          SEL_W    = calc_sel_width(DATA_WIDTH);
    localparam int unsigned          ADDR_INC = calc_addr_inc(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(ADDR_INC);
    // One extra bit so cmd_len = all-ones yields 2^LEN_WIDTH words.
    localparam logic [LEN_WIDTH:0]    WORD_ONE = (LEN_WIDTH+1)'(1);

    state_e                  state_q;
    logic                    busy_q;
    logic                    cyc_q;
    logic                    stb_q;
    logic                    we_q;
    logic [SEL_W-1:0]        sel_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_o_q;
    logic [LEN_WIDTH:0]      words_q;
    logic                    wdat_ready_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_dat_q;
    logic                    rsp_last_q;
    logic                    rsp_err_q;

    logic                    cmd_hs;
    logic                    wdat_hs;
    logic                    rsp_hs;
    logic                    last_word;
    logic [ADDR_WIDTH-1:0]   adr_d;
    logic                    tmr_load;
    logic                    tmr_count;
    logic                    tmr_expired;

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !wb_rst_i;
        cmd_hs    = cmd_valid && cmd_ready;
        wdat_hs   = wdat_valid && wdat_ready_q;
        rsp_hs    = rsp_valid_q && rsp_ready;
        last_word = (words_q == WORD_ONE);
        adr_d     = adr_q + ADR_STEP;
        // Timer restarts on every cycle that raises stb next edge.
        tmr_load  = (cmd_hs && !cmd_we)
                 || ((state_q == ST_WDAT) && wdat_hs)
                 || ((state_q == ST_RESP) && rsp_hs && !rsp_last_q);
        // stb is high in every BUS cycle, so ack is only looked at here.
        tmr_count = (state_q == ST_BUS) && !wbm_ack_i;
    end

    wb_ack_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .load_i    (tmr_load),
        .count_i   (tmr_count),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            adr_q        <= '0;
            dat_o_q      <= '0;
            words_q      <= '0;
            wdat_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_last_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        busy_q  <= 1'b1;
                        we_q    <= cmd_we;
                        sel_q   <= cmd_sel;
                        adr_q   <= cmd_adr;
                        words_q <= {1'b0, cmd_len} + WORD_ONE;
                        cyc_q   <= 1'b1;
                        if (cmd_we) begin
                            wdat_ready_q <= 1'b1;
                            state_q      <= ST_WDAT;
                        end else begin
                            stb_q   <= 1'b1;
                            state_q <= ST_BUS;
                        end
                    end
                end

                ST_WDAT: begin
                    if (wdat_hs) begin
                        dat_o_q      <= wdat;
                        wdat_ready_q <= 1'b0;
                        stb_q        <= 1'b1;
                        state_q      <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    // Ack wins over a timeout expiring in the same cycle.
                    if (wbm_ack_i) begin
                        stb_q   <= 1'b0;
                        words_q <= words_q - WORD_ONE;
                        adr_q   <= adr_d;
                        if (!we_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_dat_q   <= wbm_dat_i;
                            rsp_last_q  <= last_word;
                            rsp_err_q   <= 1'b0;
                            state_q     <= ST_RESP;
                        end else if (last_word) begin
                            rsp_valid_q <= 1'b1;
                            rsp_dat_q   <= '0;
                            rsp_last_q  <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            state_q     <= ST_RESP;
                        end else begin
                            wdat_ready_q <= 1'b1;
                            state_q      <= ST_WDAT;
                        end
                    end else if (tmr_expired) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        if (we_q && !last_word) begin
                            // words_q now counts write words not yet taken.
                            words_q      <= words_q - WORD_ONE;
                            wdat_ready_q <= 1'b1;
                            state_q      <= ST_DRAIN;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            rsp_dat_q   <= '0;
                            rsp_last_q  <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (wdat_hs) begin
                        words_q <= words_q - WORD_ONE;
                        if (last_word) begin
                            wdat_ready_q <= 1'b0;
                            rsp_valid_q  <= 1'b1;
                            rsp_dat_q    <= '0;
                            rsp_last_q   <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            state_q      <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q <= 1'b0;
                        if (rsp_last_q) begin
                            rsp_last_q <= 1'b0;
                            rsp_err_q  <= 1'b0;
                            cyc_q      <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            stb_q   <= 1'b1;
                            state_q <= ST_BUS;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign wdat_ready = wdat_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_last   = rsp_last_q;
    assign rsp_err    = rsp_err_q;
    assign wbm_cyc_o  = cyc_q;
    assign wbm_stb_o  = stb_q;
    assign wbm_we_o   = we_q;
    assign wbm_sel_o  = sel_q;
    assign wbm_adr_o  = adr_q;
    assign wbm_dat_o  = dat_o_q;

endmodule

// File: tb/tb_wb_find_master.sv
module tb_wb_find_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned TO = 4;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [3:0]    cmd_sel = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wdat_valid = 1'b0;
    logic          wdat_ready;
    logic [DW-1:0] wdat = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_last;
    logic          rsp_err;
    logic          busy;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_find_master #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    int unsigned checks = 0;
    int unsigned passes = 0;

    // ---------------- slave model + bus monitor ----------------
    logic          slave_en    = 1'b1;
    int unsigned   slave_delay = 0;
    logic [DW-1:0] slave_rdat  = '0;
    int unsigned   wait_cnt    = 0;
    int unsigned   beats       = 0;
    int unsigned   stb_high    = 0;
    int unsigned   stb_rise    = 0;
    int unsigned   cyc_fall    = 0;
    logic          stb_prev    = 1'b0;
    logic          cyc_prev    = 1'b0;
    logic [AW-1:0] log_adr [0:15];
    logic [DW-1:0] log_dat [0:15];
    logic          log_we  [0:15];
    logic [3:0]    log_sel [0:15];

    always @(posedge wb_clk_i) begin
        #1;
        if (cyc_prev && !wbm_cyc_o) cyc_fall++;
        cyc_prev = wbm_cyc_o;
        if (wbm_stb_o) stb_high++;
        if (wbm_stb_o && !stb_prev) stb_rise++;
        stb_prev = wbm_stb_o;
        if (wbm_ack_i) begin
            wbm_ack_i = 1'b0;
            wait_cnt  = 0;
        end else if (wbm_stb_o && slave_en) begin
            if (wait_cnt == slave_delay) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = wbm_we_o ? '0 : slave_rdat;
                if (beats < 16) begin
                    log_adr[beats] = wbm_adr_o;
                    log_dat[beats] = wbm_we_o ? wbm_dat_o : slave_rdat;
                    log_we[beats]  = wbm_we_o;
                    log_sel[beats] = wbm_sel_o;
                end
                beats++;
                if (!wbm_we_o) slave_rdat = slave_rdat + 1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- stream helpers (called at a negedge) ----------------
    task automatic clear_log();
        beats = 0; stb_high = 0; stb_rise = 0; cyc_fall = 0;
    endtask

    task automatic send_cmd(input logic we, input logic [AW-1:0] adr,
                            input logic [3:0] sel, input logic [LW-1:0] len);
        int unsigned n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = len;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge wb_clk_i); n++; end
        if (cmd_ready !== 1'b1) begin
            checks++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
        end
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic send_wdat(input logic [DW-1:0] v, input int unsigned gap);
        int unsigned n = 0;
        repeat (gap) @(negedge wb_clk_i);
        wdat_valid = 1'b1; wdat = v;
        while (wdat_ready !== 1'b1 && n < 50) begin @(negedge wb_clk_i); n++; end
        if (wdat_ready !== 1'b1) begin
            checks++;
            $display("FAIL wdat_accept: wdat_ready=%b required 1 within 50 cycles", wdat_ready);
        end
        @(negedge wb_clk_i);
        wdat_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int unsigned n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge wb_clk_i); n++; end
        if (rsp_valid !== 1'b1) begin
            checks++;
            $display("FAIL rsp_wait: rsp_valid=%b required 1 within 100 cycles", rsp_valid);
        end
    endtask

    task automatic get_rsp(input int unsigned hold, output logic [DW-1:0] d,
                           output logic l, output logic e);
        wait_rsp();
        repeat (hold) @(negedge wb_clk_i);
        rsp_ready = 1'b1;
        d = rsp_dat; l = rsp_last; e = rsp_err;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, rsp_valid, rsp_last, rsp_err,
             wdat_ready, cmd_ready} !== 9'b0)
            $display("FAIL reset_ctrl: got %b required 000000000",
                     {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, rsp_valid, rsp_last,
                      rsp_err, wdat_ready, cmd_ready});
        else passes++;
        checks++;
        if ({wbm_adr_o, wbm_dat_o, rsp_dat, wbm_sel_o} !== '0)
            $display("FAIL reset_data: adr=%h dat_o=%h rsp_dat=%h sel=%h required all 0",
                     wbm_adr_o, wbm_dat_o, rsp_dat, wbm_sel_o);
        else passes++;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        else passes++;
    endtask

    task automatic test_single_read();
        logic [DW-1:0] d; logic l, e;
        clear_log(); slave_delay = 2; slave_rdat = 32'hDEADBEEF;
        send_cmd(1'b0, 32'h3000_0010, 4'hF, 8'd0);
        get_rsp(0, d, l, e);
        checks++;
        if ({d, l, e} !== {32'hDEADBEEF, 1'b1, 1'b0})
            $display("FAIL single_rsp: dat=%h last=%b err=%b required deadbeef 1 0", d, l, e);
        else passes++;
        checks++;
        if (beats !== 1 || stb_rise !== 1 || log_adr[0] !== 32'h3000_0010 || log_we[0] !== 1'b0)
            $display("FAIL single_beat: beats=%0d rises=%0d adr=%h we=%b required 1 1 30000010 0",
                     beats, stb_rise, log_adr[0], log_we[0]);
        else passes++;
        checks++;
        if ({wbm_cyc_o, busy, cmd_ready} !== 3'b001)
            $display("FAIL single_idle: cyc/busy/cmd_ready=%b required 001",
                     {wbm_cyc_o, busy, cmd_ready});
        else passes++;
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] d; logic l, e; logic ok;
        clear_log(); slave_delay = 0;
        send_cmd(1'b1, 32'h3000_0000, 4'hF, 8'd3);
        send_wdat(32'd1, 2);
        send_wdat(32'd2, 0);
        send_wdat(32'd3, 3);
        send_wdat(32'd4, 1);
        wait_rsp();
        checks++;
        if (cyc_fall !== 0 || wbm_cyc_o !== 1'b1)
            $display("FAIL wr_cyc_continuous: falls=%0d cyc=%b required 0 1", cyc_fall, wbm_cyc_o);
        else passes++;
        get_rsp(0, d, l, e);
        checks++;
        if ({d, l, e} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL wr_rsp: dat=%h last=%b err=%b required 0 1 0", d, l, e);
        else passes++;
        checks++;
        if (beats !== 4 || stb_rise !== 4)
            $display("FAIL wr_beats: beats=%0d rises=%0d required 4 4", beats, stb_rise);
        else passes++;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (log_adr[i] !== 32'h3000_0000 + 32'(4*i) || log_dat[i] !== 32'(i+1) ||
                log_we[i] !== 1'b1 || log_sel[i] !== 4'hF) ok = 1'b0;
        checks++;
        if (ok !== 1'b1)
            $display("FAIL wr_beat_content: adr0..3=%h %h %h %h dat=%h %h %h %h required 30000000+4i, 1..4",
                     log_adr[0], log_adr[1], log_adr[2], log_adr[3],
                     log_dat[0], log_dat[1], log_dat[2], log_dat[3]);
        else passes++;
    endtask

    task automatic test_read_backpressure();
        logic bad; logic [DW-1:0] d; logic l, e;
        clear_log(); slave_delay = 1; slave_rdat = 32'h100;
        send_cmd(1'b0, 32'h3000_0100, 4'hF, 8'd2);
        for (int i = 0; i < 3; i++) begin
            wait_rsp();
            bad = 1'b0;
            repeat (5) begin
                if (wbm_stb_o !== 1'b0 || wbm_cyc_o !== 1'b1 || rsp_valid !== 1'b1) bad = 1'b1;
                @(negedge wb_clk_i);
            end
            rsp_ready = 1'b1;
            d = rsp_dat; l = rsp_last; e = rsp_err;
            @(negedge wb_clk_i);
            rsp_ready = 1'b0;
            checks++;
            if (bad !== 1'b0 || d !== 32'h100 + 32'(i) || l !== (i == 2) || e !== 1'b0)
                $display("FAIL rd_bp_beat%0d: hold_bad=%b dat=%h last=%b err=%b required 0 %h %b 0",
                         i, bad, d, l, e, 32'h100 + 32'(i), (i == 2));
            else passes++;
        end
        checks++;
        if (beats !== 3 || log_adr[0] !== 32'h3000_0100 || log_adr[1] !== 32'h3000_0104 ||
            log_adr[2] !== 32'h3000_0108)
            $display("FAIL rd_bp_addr: beats=%0d adr=%h %h %h required 3 30000100 30000104 30000108",
                     beats, log_adr[0], log_adr[1], log_adr[2]);
        else passes++;
    endtask

    task automatic test_write_timeout();
        logic [DW-1:0] d; logic l, e; int unsigned n = 0;
        clear_log(); slave_en = 1'b0;
        send_cmd(1'b1, 32'h3000_0040, 4'hF, 8'd2);
        send_wdat(32'hA1, 0);
        while (!(wbm_cyc_o === 1'b0 && stb_high > 0) && n < 40) begin
            @(negedge wb_clk_i); n++;
        end
        checks++;
        if (stb_high !== TO || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0)
            $display("FAIL to_stb_len: stb_cycles=%0d cyc=%b stb=%b required %0d 0 0",
                     stb_high, wbm_cyc_o, wbm_stb_o, TO);
        else passes++;
        checks++;
        if (rsp_valid !== 1'b0 || wdat_ready !== 1'b1)
            $display("FAIL to_drain_state: rsp_valid=%b wdat_ready=%b required 0 1",
                     rsp_valid, wdat_ready);
        else passes++;
        send_wdat(32'hA2, 1);
        send_wdat(32'hA3, 0);
        get_rsp(0, d, l, e);
        checks++;
        if ({d, l, e} !== {32'h0, 1'b1, 1'b1} || beats !== 0)
            $display("FAIL to_rsp: dat=%h last=%b err=%b beats=%0d required 0 1 1 0", d, l, e, beats);
        else passes++;
        checks++;
        if (cmd_ready !== 1'b1 || wdat_ready !== 1'b0 || busy !== 1'b0)
            $display("FAIL to_idle: cmd_ready=%b wdat_ready=%b busy=%b required 1 0 0",
                     cmd_ready, wdat_ready, busy);
        else passes++;
        slave_en = 1'b1;
    endtask

    task automatic test_addr_wrap();
        logic [DW-1:0] d0, d1; logic l0, l1, e0, e1;
        clear_log(); slave_delay = 0; slave_rdat = 32'h5000;
        send_cmd(1'b0, 32'hFFFF_FFFC, 4'h3, 8'd1);
        get_rsp(0, d0, l0, e0);
        get_rsp(0, d1, l1, e1);
        checks++;
        if (beats !== 2 || log_adr[0] !== 32'hFFFF_FFFC || log_adr[1] !== 32'h0 || log_sel[1] !== 4'h3)
            $display("FAIL wrap_addr: beats=%0d adr=%h %h sel=%h required 2 fffffffc 00000000 3",
                     beats, log_adr[0], log_adr[1], log_sel[1]);
        else passes++;
        checks++;
        if ({d0, l0, d1, l1} !== {32'h5000, 1'b0, 32'h5001, 1'b1})
            $display("FAIL wrap_rsp: %h/%b %h/%b required 5000/0 5001/1", d0, l0, d1, l1);
        else passes++;
    endtask

    task automatic test_max_len();
        logic [DW-1:0] d; logic l, e; logic last_ok; int unsigned lasts = 0;
        clear_log(); slave_delay = 0; slave_rdat = 32'h7000;
        send_cmd(1'b0, 32'h3000_0000, 4'hF, 8'hFF);
        last_ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            get_rsp(0, d, l, e);
            if (l) lasts++;
            if (l !== (i == 255) || e !== 1'b0 || d !== 32'h7000 + 32'(i)) last_ok = 1'b0;
        end
        checks++;
        if (beats !== 256 || lasts !== 1 || last_ok !== 1'b1)
            $display("FAIL maxlen: beats=%0d lasts=%0d seq_ok=%b required 256 1 1", beats, lasts, last_ok);
        else passes++;
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL maxlen_idle: busy=%b cmd_ready=%b required 0 1", busy, cmd_ready);
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] d; logic l, e; logic activity; int unsigned n = 0;
        clear_log(); slave_delay = 2; slave_rdat = 32'h600;
        send_cmd(1'b0, 32'h3000_0200, 4'hF, 8'd3);
        get_rsp(0, d, l, e);
        while (wbm_stb_o !== 1'b1 && n < 20) begin @(negedge wb_clk_i); n++; end
        checks++;
        if (wbm_stb_o !== 1'b1 || d !== 32'h600 || l !== 1'b0)
            $display("FAIL rst_mid_setup: stb=%b dat=%h last=%b required 1 600 0", wbm_stb_o, d, l);
        else passes++;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready} !== 5'b0)
            $display("FAIL rst_mid_drop: cyc/stb/rsp_valid/busy/cmd_ready=%b required 00000",
                     {wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready});
        else passes++;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b required 1", cmd_ready);
        else passes++;
        activity = 1'b0;
        repeat (10) begin
            if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) activity = 1'b1;
            @(negedge wb_clk_i);
        end
        checks++;
        if (activity !== 1'b0 || beats !== 1)
            $display("FAIL rst_mid_quiet: activity=%b beats=%0d required 0 1", activity, beats);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_read_backpressure();
        test_write_timeout();
        test_addr_wrap();
        test_max_len();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/wb_find_master.md
Name: wb_find_master

Overview:
Wishbone classic-cycle initiator that issues single and incrementing-burst reads and writes into the wb_find register space. Commands, write data and responses travel on valid/ready streams. It is the bus-master counterpart to the wb_find slave: it drives the same wbs_* signal set from the master side, for LA-driven self-test and bulk sequence loading. It adds a per-beat ack timeout, so a missing or dead slave can never hang the bus.

Parameters:
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; SEL width = DATA_WIDTH/8
LEN_WIDTH, 8, burst length field width; words per command = cmd_len+1
TIMEOUT_CYCLES, 256, maximum cycles stb may be held without ack (must be >=2)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_we  in  1  1 = write burst, 0 = read burst
cmd_adr  in  ADDR_WIDTH  start byte address
cmd_sel  in  DATA_WIDTH/8  byte lanes, constant for the whole burst
cmd_len  in  LEN_WIDTH  words minus one
wdat_valid  in  1  write data word offered
wdat_ready  out  1  write data accepted
wdat  in  DATA_WIDTH  write data word
rsp_valid  out  1  response beat valid
rsp_ready  in  1  response consumer ready
rsp_dat  out  DATA_WIDTH  read data (0 for write status)
rsp_last  out  1  final beat of the command
rsp_err  out  1  timeout occurred
busy  out  1  command in progress
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  DATA_WIDTH/8  byte select
wbm_adr_o  out  ADDR_WIDTH  address
wbm_dat_o  out  DATA_WIDTH  write data
wbm_dat_i  in  DATA_WIDTH  read data
wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset: every registered output is 0, including wbm_*, rsp_*, busy and wdat_ready. cmd_ready is forced 0 while wb_rst_i=1. The FSM enters IDLE.
- States are IDLE, WDAT, BUS, RESP, DRAIN.
- IDLE: cmd_ready=1.
  - On handshake at cycle T, latch we/adr/sel/len and set busy=1 at T+1.
  - A read goes to BUS, with cyc=stb=1 at T+1.
  - A write goes to WDAT.
- WDAT: wdat_ready=1 and cyc=1, stb=0. On the wdat handshake at W, load wbm_dat_o and go to BUS; stb=1 at W+1.
- BUS: cyc=stb=1, with adr/we/sel/dat held stable. wbm_ack_i sampled high at cycle A ends the beat:
  - stb=0 at A+1.
  - For a read, wbm_dat_i is captured into rsp_dat.
  - The word counter decrements and the address advances by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
- After an ack:
  - A read goes to RESP: rsp_valid=1 at A+1 and rsp_last=1 on the final word.
  - A write with words remaining goes to WDAT.
  - A write on its final word goes to RESP: rsp_valid=1, rsp_last=1, rsp_dat=0, rsp_err=0.
- RESP: rsp_valid is held until rsp_ready. After handshake at H:
  - If words remain, the read goes to BUS with stb=1 at H+1.
  - Otherwise go to IDLE: cyc=0 and busy=0 at H+1, and cmd_ready=1 at H+1.
- cyc stays 1 from the first stb to the final ack, including during rsp/wdat backpressure.
- wbm_ack_i is ignored whenever stb=0.
- Timeout:
  - The counter clears on each stb rising and counts each BUS cycle without ack.
  - After TIMEOUT_CYCLES such cycles, cyc=stb=0 on the next cycle. Emit one beat with rsp_err=1, rsp_last=1, rsp_dat=0, and abandon the remaining words.
  - For a write with words still unconsumed, go to DRAIN first. DRAIN holds wdat_ready=1 and discards exactly the remaining words, keeping the stream aligned; the error beat is emitted after the drain.
- Ack arriving in the same cycle the timeout expires counts as success.
- cmd_len = max value gives 2^LEN_WIDTH words, with no overflow.
- Reset mid-burst: cyc/stb drop on the cycle after the reset edge, no response is emitted, and the stream state is discarded.

Decomposition:
- Shared package wb_find_master_pkg: FSM state enum, SEL_WIDTH = DATA_WIDTH/8 and ADDR_INC = DATA_WIDTH/8 derivation, and a TIMEOUT counter width function (clog2).
- One natural sub-module, wb_ack_timer: load/count/expire timer with a TIMEOUT_CYCLES parameter.

Test Plan:
1. Single read: cmd we=0, adr=0x3000_0010, sel=0xF, len=0; slave acks 2 cycles after stb with 0xDEADBEEF -> exactly one stb beat at 0x3000_0010; rsp_dat=0xDEADBEEF, last=1, err=0; cyc low after the rsp handshake.
2. Write burst: len=3, adr=0x3000_0000; wdat 1,2,3,4 with gaps; slave acks immediately -> four stb beats at 0x…00/04/08/0C carrying 1..4, stb low ≥1 cycle between beats, cyc continuous; one rsp beat with last=1, dat=0, err=0.
3. Read burst with backpressure: len=2, rsp_ready held low 5 cycles per beat -> stb stays low while rsp is pending, cyc stays high; three beats in order, last only on the third.
4. Timeout on write: TIMEOUT_CYCLES=4, len=2, no ack -> stb high exactly 4 cycles, then cyc=stb=0; the two remaining wdat words are drained; one beat with err=1, last=1; cmd_ready returns.
5. Address wrap: adr=0xFFFF_FFFC, len=1 read -> second beat adr=0x0000_0000.
6. Reset mid-burst: assert wb_rst_i during the BUS of beat 2 of a 4-word read -> cyc/stb/rsp_valid/busy=0 on the cycle after the reset edge, no further beats; cmd_ready=1 after reset deasserts.
